// File: rtl/sd_dat_rx_ctrl.sv
// sd_dat_rx_ctrl: receive sequencer for one SD DAT line (DAT0, 1-bit mode).
// Waits for the card start bit, frames the block into 32-bit MSB-first
// words, consumes the 16-bit CRC, checks the end bit and reports done.
// Optional CRC16-CCITT check over the data bits: define SD_DAT_CRC_CHECK_EN.
module sd_dat_rx_ctrl #(
    parameter int BLK_W = 10,
    parameter int TO_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [BLK_W-1:0] blocksize,
    input  logic [TO_W-1:0]  timeout,
    input  logic             dat_in,
    output logic [31:0]      word_out,
    output logic             word_valid,
    output logic             busy,
    output logic             done,
    output logic             crc_err,
    output logic             end_err,
    output logic             timeout_err
);

    typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END, DONE} state_t;

    localparam logic [BLK_W-3:0] WORD_ONE = {{(BLK_W-3){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic             accept;
    logic             last_word;
    logic [BLK_W-3:0] nwords_in;
    logic [BLK_W-3:0] nwords;
    logic [BLK_W-3:0] wcnt;
    logic [TO_W-1:0]  tcnt;
    logic [4:0]       bitcnt;
    logic [30:0]      shreg;
    logic             unused_bs_lsbs;

    // Request decode: block length in words, zero-length treated as one word.
    always_comb begin
        accept         = (state == IDLE) && start && !abort;
        unused_bs_lsbs = ^blocksize[1:0];
        nwords_in      = blocksize[BLK_W-1:2];
        if (nwords_in == '0)
            nwords_in = WORD_ONE;
        last_word      = (wcnt == (nwords - WORD_ONE));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE:       if (start) state_nxt = WAIT_START;
            WAIT_START: begin
                if (!dat_in)
                    state_nxt = DATA;
                else if (tcnt == '0)
                    state_nxt = DONE;
            end
            DATA:       if (bitcnt == 5'd31 && last_word) state_nxt = CRC;
            CRC:        if (bitcnt[3:0] == 4'd15) state_nxt = END;
            END:        state_nxt = DONE;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
        if (abort)
            state_nxt = IDLE;
    end

    // Datapath: counters, word shifter, end-bit and timeout flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            nwords      <= '0;
            wcnt        <= '0;
            tcnt        <= '0;
            bitcnt      <= '0;
            shreg       <= '0;
            word_out    <= '0;
            word_valid  <= 1'b0;
            end_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        nwords      <= nwords_in;
                        tcnt        <= timeout;
                        wcnt        <= '0;
                        bitcnt      <= '0;
                        end_err     <= 1'b0;
                        timeout_err <= 1'b0;
                    end
                end
                WAIT_START: begin
                    if (dat_in) begin
                        if (tcnt != '0)
                            tcnt <= tcnt - 1'b1;
                        else if (!abort)
                            timeout_err <= 1'b1;
                    end
                end
                DATA: begin
                    shreg  <= {shreg[29:0], dat_in};
                    bitcnt <= bitcnt + 5'd1;
                    if (bitcnt == 5'd31) begin
                        wcnt <= wcnt + WORD_ONE;
                        if (!abort) begin
                            word_out   <= {shreg, dat_in};
                            word_valid <= 1'b1;
                        end
                    end
                end
                CRC: begin
                    bitcnt <= bitcnt + 5'd1;
                end
                END: begin
                    if (!abort && !dat_in)
                        end_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SD_DAT_CRC_CHECK_EN
    logic [15:0] crc_calc;
    logic [15:0] crc_rx;

    // CRC16-CCITT over data bits; comparison registered on leaving END so
    // crc_err is already valid during the done cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            crc_calc <= '0;
            crc_rx   <= '0;
            crc_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        crc_calc <= '0;
                        crc_err  <= 1'b0;
                    end
                end
                DATA: begin
                    crc_calc <= {crc_calc[14:0], 1'b0} ^
                                ({16{crc_calc[15] ^ dat_in}} & 16'h1021);
                end
                CRC: begin
                    crc_rx <= {crc_rx[14:0], dat_in};
                end
                END: begin
                    if (!abort)
                        crc_err <= (crc_calc != crc_rx);
                end
                default: ;
            endcase
        end
    end
`else
    // CRC field is consumed for timing only; no check is made.
    always_comb crc_err = 1'b0;
`endif

endmodule
